// File: rtl/amp_pkg.sv
// Shared types and constants for the amplifier write-side initiator.
// Widths here are the defaults the top-level parameters are built around.
package amp_pkg;

  localparam int WR_DATA_WIDTH = 16;
  localparam int RD_DATA_WIDTH = 32;
  localparam int SCALER_WIDTH  = 16;
  localparam int TAG_WIDTH     = 8;
  localparam int RES_WIDTH     = 24;

  localparam int ERR_UNEXPECTED = 0;
  localparam int ERR_RESP       = 1;
  localparam int ERR_SCALER     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_ISSUE,
    ST_CFG_CHECK,
    ST_RUN,
    ST_DRAIN
  } amp_mst_state_e;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [RES_WIDTH-1:0] res;
  } amp_res_t;

endpackage

// File: rtl/amp_res_fifo.sv
// First-word fall-through result FIFO with occupancy count.
// Push is dropped only when full with no pop; the master's credit check keeps that from happening.
module amp_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/amp_master.sv
// Write-side initiator for the amplifier: issues scaler/base writes, tracks tags
// through a latency-matched shift register and queues checked results for downstream.
module amp_master #(
  parameter int WR_DATA_WIDTH = 16,
  parameter int RD_DATA_WIDTH = 32,
  parameter int SCALER_WIDTH  = 16,
  parameter int AMP_LAT       = 1,
  parameter int RES_DEPTH     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [SCALER_WIDTH-1:0]       cfg_scaler_i,
  input  logic                          base_valid_i,
  output logic                          base_ready_o,
  input  logic [7:0]                    base_data_i,
  output logic                          amp_wr_en_o,
  output logic                          amp_set_scaler_o,
  output logic [WR_DATA_WIDTH-1:0]      amp_wr_data_o,
  input  logic                          amp_rd_val_i,
  input  logic [RD_DATA_WIDTH-1:0]      amp_rd_data_i,
  input  logic [SCALER_WIDTH-1:0]       amp_scaler_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [amp_pkg::RES_WIDTH-1:0] res_data_o,
  output logic [amp_pkg::TAG_WIDTH-1:0] res_tag_o,
  output logic [2:0]                    err_o,
  output logic                          busy_o
);
  import amp_pkg::*;

  localparam int STAGES = AMP_LAT + 1;
  localparam int CNT_W  = $clog2(RES_DEPTH + 1);
  localparam int CRED_W = CNT_W + 8;
  localparam int LAT_W  = (AMP_LAT > 1) ? $clog2(AMP_LAT) : 1;
  localparam int RES_W  = $bits(amp_res_t);

  amp_mst_state_e           state_q, state_d;
  logic [TAG_WIDTH-1:0]     tag_q, tag_d;
  logic [SCALER_WIDTH-1:0]  scaler_q, scaler_d;
  logic                     wr_en_q, wr_en_d, set_q, set_d;
  logic [WR_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [2:0]               err_q, err_d;
  logic [LAT_W-1:0]         chk_q, chk_d;

  logic                 vld_q   [STAGES];
  logic                 vld_in  [STAGES];
  logic [TAG_WIDTH-1:0] ptag_q  [STAGES];
  logic [TAG_WIDTH-1:0] ptag_in [STAGES];

  logic                 base_hs, take_cfg, credit_ok;
  logic [CRED_W-1:0]    inflight;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_push, fifo_valid;
  logic                 tail_vld;
  logic [TAG_WIDTH-1:0] tail_tag, rsp_tag;
  amp_res_t             push_data, head_data;

  // Stage 0 coincides with the write on the bus; the tail lines up with rd_val.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign vld_in[gi]  = base_hs;
      assign ptag_in[gi] = tag_q;
    end else begin : g_body
      assign vld_in[gi]  = vld_q[gi-1];
      assign ptag_in[gi] = ptag_q[gi-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_q[gi]  <= 1'b0;
        ptag_q[gi] <= '0;
      end else begin
        vld_q[gi]  <= vld_in[gi];
        ptag_q[gi] <= ptag_in[gi];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflight = inflight + CRED_W'(vld_q[i]);
    end
  end

  assign credit_ok = (CRED_W'(fifo_count) + inflight) < CRED_W'(RES_DEPTH);
  assign tail_vld  = vld_q[STAGES-1];
  assign tail_tag  = ptag_q[STAGES-1];
  assign rsp_tag   = amp_rd_data_i[RD_DATA_WIDTH-1 -: TAG_WIDTH];
  assign fifo_push = tail_vld & amp_rd_val_i;
  // A mismatched tag is still queued, but under the tag we expected.
  assign push_data = {tail_tag, amp_rd_data_i[RES_WIDTH-1:0]};

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    scaler_d     = scaler_q;
    wr_en_d      = 1'b0;
    set_d        = 1'b0;
    wr_data_d    = wr_data_q;
    chk_d        = chk_q;
    err_d        = err_q;
    cfg_ready_o  = 1'b0;
    base_ready_o = 1'b0;
    base_hs      = 1'b0;
    take_cfg     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cfg_ready_o = 1'b1;
        take_cfg    = cfg_valid_i;
      end
      ST_CFG_ISSUE: begin
        state_d = ST_CFG_CHECK;
        chk_d   = '0;
      end
      ST_CFG_CHECK: begin
        if (chk_q == LAT_W'(AMP_LAT - 1)) begin
          if (amp_scaler_i != scaler_q) err_d[ERR_SCALER] = 1'b1;
          state_d = ST_RUN;
        end else begin
          chk_d = chk_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (cfg_valid_i) begin
          if (inflight == '0) begin
            cfg_ready_o = 1'b1;
            take_cfg    = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          base_ready_o = credit_ok;
          base_hs      = base_valid_i & credit_ok;
        end
      end
      ST_DRAIN: begin
        if (inflight == '0) begin
          cfg_ready_o = 1'b1;
          if (cfg_valid_i) take_cfg = 1'b1;
          else             state_d  = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_cfg) begin
      scaler_d  = cfg_scaler_i;
      wr_en_d   = 1'b1;
      set_d     = 1'b1;
      wr_data_d = WR_DATA_WIDTH'(cfg_scaler_i);
      state_d   = ST_CFG_ISSUE;
    end
    if (base_hs) begin
      wr_en_d   = 1'b1;
      wr_data_d = WR_DATA_WIDTH'({tag_q, base_data_i});
      tag_d     = tag_q + 1'b1;
    end

    if (tail_vld && (!amp_rd_val_i || (rsp_tag != tail_tag))) err_d[ERR_RESP] = 1'b1;
    if (!tail_vld && amp_rd_val_i) err_d[ERR_UNEXPECTED] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tag_q     <= '0;
      scaler_q  <= '0;
      wr_en_q   <= 1'b0;
      set_q     <= 1'b0;
      wr_data_q <= '0;
      err_q     <= '0;
      chk_q     <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      scaler_q  <= scaler_d;
      wr_en_q   <= wr_en_d;
      set_q     <= set_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      chk_q     <= chk_d;
    end
  end

  amp_res_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (RES_W)
  ) u_res_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (push_data),
    .pop_i       (res_ready_i),
    .head_o      (head_data),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign amp_wr_en_o      = wr_en_q;
  assign amp_set_scaler_o = set_q;
  assign amp_wr_data_o    = wr_data_q;
  assign res_valid_o      = fifo_valid;
  assign res_data_o       = head_data.res;
  assign res_tag_o        = head_data.tag;
  assign err_o            = err_q;
  assign busy_o           = ((state_q != ST_IDLE) && (state_q != ST_RUN)) || (inflight != '0);

endmodule

// File: doc/amp_master.md
Name: amp_master

Overview:
- Write-side initiator for the amplifier block.
- Accepts a scaler configuration and a stream of 8-bit base numbers from upstream, and drives the amplifier's wr_en/set_scaler/wr_data write interface.
- Assigns each base number an 8-bit sequence number ("no") and checks the amplifier's rd_val/rd_data responses against it.
- Buffers results in a small FIFO so downstream can backpressure, even though the amplifier itself cannot.

Parameters:
- WR_DATA_WIDTH, 16, amplifier write word: {no[7:0], base[7:0]} or scaler value.
- RD_DATA_WIDTH, 32, amplifier read word: {no[7:0], res[23:0]}.
- SCALER_WIDTH, 16, scaler width.
- AMP_LAT, 1, cycles from amp_wr_en_o sampled to amp_rd_val_i asserted.
- RES_DEPTH, 4, result FIFO entries (power of two, >= 2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- cfg_valid_i  in  1  scaler configuration request.
- cfg_ready_o  out  1  configuration accepted this cycle.
- cfg_scaler_i  in  SCALER_WIDTH  new scaler value.
- base_valid_i  in  1  base number offered.
- base_ready_o  out  1  base number accepted this cycle.
- base_data_i  in  8  base number.
- amp_wr_en_o  out  1  to amplifier wr_en_i.
- amp_set_scaler_o  out  1  to amplifier set_scaler_i.
- amp_wr_data_o  out  WR_DATA_WIDTH  to amplifier wr_data_i.
- amp_rd_val_i  in  1  from amplifier rd_val_o.
- amp_rd_data_i  in  RD_DATA_WIDTH  from amplifier rd_data_o.
- amp_scaler_i  in  SCALER_WIDTH  from amplifier scaler_o.
- res_valid_o  out  1  result available (FIFO not empty).
- res_ready_i  in  1  downstream pops the result.
- res_data_o  out  24  product base*scaler.
- res_tag_o  out  8  sequence number of the result.
- err_o  out  3  sticky: [0] unexpected response, [1] missing response or tag mismatch, [2] scaler readback mismatch.
- busy_o  out  1  state != IDLE/RUN, or writes in flight.

Behaviour:
- Reset values: all amp_* outputs 0; res_valid_o 0; err_o 0; tag counter 0; FIFO empty; state IDLE; busy_o 0.
- Reset asserted mid-operation discards everything in flight, with no output glitches beyond the return to reset values.
- States:
  - IDLE: base_ready_o=0, cfg_ready_o=1.
  - CFG_ISSUE: one cycle with amp_wr_en_o=1, amp_set_scaler_o=1, amp_wr_data_o=latched scaler.
  - CFG_CHECK: waits AMP_LAT cycles, then compares amp_scaler_i to the latched value. On mismatch, set err_o[2]. Go to RUN in either case.
  - RUN: streams base writes.
  - DRAIN: a cfg request is pending while writes are in flight. Wait until in-flight reaches 0, then go to CFG_ISSUE.
- Transitions:
  - IDLE --cfg handshake--> CFG_ISSUE.
  - RUN --cfg_valid_i, inflight=0--> CFG_ISSUE (cfg_ready_o=1 that cycle).
  - RUN --cfg_valid_i, inflight>0--> DRAIN.
  - DRAIN --inflight=0--> CFG_ISSUE, with the handshake taken in that cycle.
- cfg/base priority: cfg_valid_i wins over base_valid_i in RUN. base_ready_o=0 in any cycle where cfg_valid_i=1.
- Base issue conditions: base_ready_o = (state==RUN) & !cfg_valid_i & (fifo_count + inflight < RES_DEPTH).
- Base issue timing: a base accepted at cycle t produces amp_wr_en_o=1, amp_set_scaler_o=0, amp_wr_data_o={tag,base} at t+1 (outputs registered). The tag then increments, wrapping 255->0. A cfg change does not reset the tag.
- Idle write bus: whenever no write is issued, amp_wr_en_o=0 and amp_set_scaler_o=0, and amp_wr_data_o holds its last value.
- In-flight tracking: an AMP_LAT+1 stage shift register of {valid, tag}. inflight = number of valid stages. Throughput is one base per cycle when unblocked.
- Response check, at the tail stage:
  - Tail valid, amp_rd_val_i=1, amp_rd_data_i[31:24]==tag: push {tag, res} into the FIFO.
  - Tail valid, rd_val=0: set err_o[1], push nothing.
  - Tail valid, tag differs: set err_o[1], push with the expected tag.
  - Tail empty, rd_val=1: set err_o[0], ignore the data. This includes any rd_val during CFG_CHECK.
- FIFO behaviour:
  - First-word fall-through; res_data_o/res_tag_o reflect the head.
  - Simultaneous push and pop are allowed at any occupancy.
  - Overflow is impossible by credit accounting.
  - Pop on empty is ignored.
- Error flags: err_o bits clear only on reset.

Decomposition:
- Shared package amp_pkg:
  - Width constants WR_DATA_WIDTH, RD_DATA_WIDTH, SCALER_WIDTH, TAG_WIDTH=8, RES_WIDTH=24.
  - State enum amp_mst_state_e.
  - Err bit index constants.
  - Packed struct for {tag, res}.
- One sub-module: amp_res_fifo, a synchronous FWFT FIFO with count output, parameterised on depth and width.

Test Plan:
- Reset, then cfg 100 -> next cycle amp_wr_en_o=1, set_scaler=1, wr_data=100. AMP_LAT cycles later amp_scaler_i=100, err_o=0, state RUN.
- Base 25 after scaler 100 -> amp_wr_data_o=16'h0019. Model returns {8'd0, 24'd2500} -> res_valid_o=1, res_data_o=2500, res_tag_o=0.
- res_ready_i=0, offer 8 bases back-to-back -> exactly 4 accepted, base_ready_o low afterwards. Then release -> tags 0..3 in order, next 4 accepted.
- 258 bases with res_ready_i=1 -> tags ...,254,255,0,1 in order, no errors.
- Model drops one response -> err_o[1]. Model asserts rd_val with nothing in flight -> err_o[0]. Model reports scaler 99 after cfg 100 -> err_o[2]. All stay set until rst_i.
- cfg 7 asserted while base writes are in flight -> DRAIN, no base accepted, then set_scaler write. rst_i asserted mid-stream -> outputs return to reset values asynchronously, FIFO empty, next tag 0.
